matriz_scan: RTL and testbench
==============================

Name: matriz_scan

Overview:
- Parametrised column-multiplexed LED matrix driver; next generation of the fixed 5x7 column scanner.
- Adds configurable geometry, per-column dwell time, inter-column blanking (anti-ghosting), output polarity, and a double-buffered frame load handshake with tear-free swap at frame boundary.
- Sits between display/character logic (frame producer) and matrix pins.

Parameters:
- NUM_COLS, 5, number of columns scanned (>=1).
- NUM_ROWS, 7, number of row lines (>=1).
- DWELL, 4, clock cycles a column is shown per slot (>=1).
- BLANK_CYCLES, 1, all-off cycles before each column's show period (>=0; 0 removes blanking).
- COL_ACTIVE_LOW, 0, 1 = column drive asserted low.
- ROW_ACTIVE_LOW, 0, 1 = row drive asserted low.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- frame_data  input  NUM_COLS*NUM_ROWS  new frame; column c = frame_data[c*NUM_ROWS +: NUM_ROWS], bit r = row r lit (logical 1 = on).
- frame_valid  input  1  producer offers frame_data.
- frame_ready  output  1  pending buffer empty; transfer when frame_valid && frame_ready.
- colunas  output  NUM_COLS  one-hot column drive (polarity per COL_ACTIVE_LOW).
- linhas  output  NUM_ROWS  row drive (polarity per ROW_ACTIVE_LOW).
- col_index  output  max(1,$clog2(NUM_COLS))  column currently in its slot.
- frame_start  output  1  one-cycle pulse on first cycle of column 0 slot.

Behaviour:
- Clock is clock; reset is synchronous, active-high. All outputs decoded from registers only; no combinational input-to-output path.
- Reset: state=BLANK (SHOW if BLANK_CYCLES=0), col_index=0, cycle counter=0, active buffer=0, pending empty, frame_ready=1, frame_start=0, colunas and linhas at inactive level (all 0, or all 1 when active-low). Reset mid-frame or mid-transfer discards pending frame and active content.
- Slot per column = BLANK_CYCLES + DWELL cycles; frame period = NUM_COLS*(BLANK_CYCLES+DWELL). Example defaults: 25 cycles.
- FSM: BLANK (colunas, linhas inactive) for BLANK_CYCLES cycles -> SHOW (colunas bit col_index asserted, linhas = active[col_index] in drive polarity) for DWELL cycles -> next slot. Skip BLANK entirely when BLANK_CYCLES=0.
- col_index increments at end of SHOW; wraps NUM_COLS-1 -> 0. NUM_COLS=1: stays 0.
- First cycle after reset release is cycle 0 of column 0 slot; frame_start=1 that cycle and on first cycle of every column 0 slot.
- Handshake: on frame_valid && frame_ready, frame_data captured into pending; frame_ready drops next cycle. frame_data ignored when frame_ready=0.
- Swap: on the edge where col_index wraps to 0, if pending full, active <= pending and frame_ready rises next cycle. Active never changes mid-frame.
- Acceptance on the wrap edge itself: the frame is captured into pending but not swapped; swap occurs at the following wrap.
- Cycle counter width sized for max(DWELL, BLANK_CYCLES); no overflow states reachable.

Optional Feature:
- Macro MATRIZ_SCAN_BRIGHTNESS_EN.
- Defined: extra input brightness [3:0], sampled at first cycle of each slot. In SHOW cycle s (0..DWELL-1), linhas driven with data only if s*15 < brightness*DWELL, else inactive; colunas stays asserted. brightness=15: full; brightness=0: rows always inactive.
- Not defined: no brightness port; rows driven for the whole SHOW period.

Test Plan:
- Defaults, reset 3 cycles then release, no frame -> cycle 0 frame_start=1; colunas/linhas all 0 throughout; col_index 0,1,2,3,4 at 5-cycle steps, wrap at cycle 25.
- Offer frame cols 0..4 = 7'h01,02,04,08,10 at cycle 3 -> frame_ready=0 from cycle 4; first frame still blank; from cycle 25: cycle 25 blank, cycles 26-29 colunas=5'b00001 linhas=7'h01; column 4 shows 7'h10 at cycles 46-49; frame_ready=1 at cycle 26.
- Second frame offered while pending full -> not captured, frame_valid held; captured when frame_ready rises, displayed one frame later; no mixed-frame column observed.
- COL_ACTIVE_LOW=1, ROW_ACTIVE_LOW=1, BLANK_CYCLES=0, NUM_COLS=8, NUM_ROWS=8, DWELL=2 -> blank-frame idle colunas=8'hFF linhas=8'hFF; after load, shown column bit low, lit rows low; period 16 cycles.
- Assert reset during SHOW of column 2 with pending full -> next cycle outputs inactive, col_index=0, frame_ready=1, display blank after release.
- With MATRIZ_SCAN_BRIGHTNESS_EN, DWELL=4, brightness=8, column all-on -> rows lit SHOW cycles 0-2 (s*15 < 32), off cycle 3; brightness=0 -> rows never lit.

Source files
------------

// File: rtl/matriz_scan.sv
`default_nettype none
// ============================================================================
// Module   : matriz_scan
// Purpose  : Column-multiplexed LED matrix driver. Scans NUM_COLS columns,
//            each slot being BLANK_CYCLES all-off cycles followed by DWELL
//            cycles of the column shown. Frames are loaded through a
//            valid/ready handshake into a pending buffer and are swapped
//            into the displayed buffer only when the scan wraps to column 0,
//            so a frame is never torn.
// Ports    : clock        - system clock, rising edge
//            reset        - synchronous, active-high
//            frame_data   - frame; column c = frame_data[c*NUM_ROWS +: NUM_ROWS]
//            frame_valid  - producer offers frame_data
//            frame_ready  - pending buffer empty
//            brightness   - (optional) 4-bit row duty within SHOW
//            colunas      - one-hot column drive (polarity COL_ACTIVE_LOW)
//            linhas       - row drive (polarity ROW_ACTIVE_LOW)
//            col_index    - column currently in its slot
//            frame_start  - pulse on first cycle of the column 0 slot
// Options  : MATRIZ_SCAN_BRIGHTNESS_EN adds the brightness input.
// Revision : 1.0 - initial release
// ============================================================================
module matriz_scan #(
    parameter int NUM_COLS       = 5,
    parameter int NUM_ROWS       = 7,
    parameter int DWELL          = 4,
    parameter int BLANK_CYCLES   = 1,
    parameter int COL_ACTIVE_LOW = 0,
    parameter int ROW_ACTIVE_LOW = 0
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic [NUM_COLS*NUM_ROWS-1:0]                     frame_data,
    input  logic                                             frame_valid,
    output logic                                             frame_ready,
`ifdef MATRIZ_SCAN_BRIGHTNESS_EN
    input  logic [3:0]                                       brightness,
`endif
    output logic [NUM_COLS-1:0]                              colunas,
    output logic [NUM_ROWS-1:0]                              linhas,
    output logic [((NUM_COLS > 1) ? $clog2(NUM_COLS) : 1)-1:0] col_index,
    output logic                                             frame_start
);

    localparam int C_COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int C_CNT_MAX = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
    localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;
    localparam int C_FRAME_W = NUM_COLS * NUM_ROWS;

    localparam logic [C_CNT_W-1:0]  C_DWELL_LAST = C_CNT_W'(DWELL - 1);
    localparam logic [C_CNT_W-1:0]  C_BLANK_LAST = C_CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [C_COL_W-1:0]  C_COL_LAST   = C_COL_W'(NUM_COLS - 1);
    localparam logic [NUM_COLS-1:0] C_COL_OFF    = (COL_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [NUM_ROWS-1:0] C_ROW_OFF    = (ROW_ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Each slot opens in BLANK unless blanking is configured away.
    localparam state_t C_SLOT_FIRST = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

    state_t                 state_q, state_d;
    logic [C_COL_W-1:0]     col_q, col_d;
    logic [C_CNT_W-1:0]     cnt_q, cnt_d;
    logic                   started_q, started_d;
    logic                   loaded_q, loaded_d;
    logic [C_FRAME_W-1:0]   active_q, active_d;
    logic [C_FRAME_W-1:0]   pending_q, pending_d;
    logic                   pending_full_q, pending_full_d;
    logic                   swap_done_q, swap_done_d;
    logic [NUM_COLS-1:0]    colunas_q, colunas_d;
    logic [NUM_ROWS-1:0]    linhas_q, linhas_d;
    logic                   frame_start_q, frame_start_d;
`ifdef MATRIZ_SCAN_BRIGHTNESS_EN
    logic [3:0]             bri_q, bri_d;
`endif

    logic                   w_wrap;
    logic                   w_slot_start;
    logic                   w_rows_lit;
    logic [NUM_COLS-1:0]    w_col_onehot;
    logic [NUM_ROWS-1:0]    w_row_sel;

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        cnt_d          = cnt_q;
        started_d      = 1'b1;
        loaded_d       = loaded_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        swap_done_d    = 1'b0;
        w_wrap         = 1'b0;

        // The first cycle out of reset only arms the scan, so the cycle that
        // follows is cycle 0 of the column 0 slot with frame_start raised.
        if (started_q) begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == C_BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == C_DWELL_LAST) begin
                        cnt_d   = '0;
                        state_d = C_SLOT_FIRST;
                        if (col_q == C_COL_LAST) begin
                            col_d  = '0;
                            w_wrap = 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end

        // Tear-free swap: the displayed buffer only changes on the wrap edge.
        // The pending buffer is released one cycle later so frame_ready rises
        // on the second cycle of the new frame.
        if (w_wrap && pending_full_q) begin
            active_d    = pending_q;
            loaded_d    = 1'b1;
            swap_done_d = 1'b1;
        end
        if (swap_done_q) begin
            pending_full_d = 1'b0;
        end
        if (frame_valid && !pending_full_q) begin
            pending_d      = frame_data;
            pending_full_d = 1'b1;
        end

        w_slot_start  = (state_d == C_SLOT_FIRST) && (cnt_d == '0);
        frame_start_d = w_slot_start && (col_d == '0);

        w_col_onehot = '0;
        w_row_sel    = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_d == C_COL_W'(c)) begin
                w_col_onehot[c] = 1'b1;
                w_row_sel       = active_d[c*NUM_ROWS +: NUM_ROWS];
            end
        end

`ifdef MATRIZ_SCAN_BRIGHTNESS_EN
        // Brightness is captured on the edge that opens each slot and held
        // for the whole slot; rows light for the first fraction of SHOW.
        bri_d      = w_slot_start ? brightness : bri_q;
        w_rows_lit = (state_d == ST_SHOW) &&
                     ((32'(cnt_d) * 32'd15) < (32'(bri_d) * 32'(DWELL)));
`else
        w_rows_lit = (state_d == ST_SHOW);
`endif

        // No column is driven until a frame has been loaded, so an empty
        // display stays fully dark.
        colunas_d = (((state_d == ST_SHOW) && loaded_d) ? w_col_onehot : '0) ^ C_COL_OFF;
        linhas_d  = ((w_rows_lit && loaded_d) ? w_row_sel : '0) ^ C_ROW_OFF;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= C_SLOT_FIRST;
            col_q          <= '0;
            cnt_q          <= '0;
            started_q      <= 1'b0;
            loaded_q       <= 1'b0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            swap_done_q    <= 1'b0;
            colunas_q      <= C_COL_OFF;
            linhas_q       <= C_ROW_OFF;
            frame_start_q  <= 1'b0;
`ifdef MATRIZ_SCAN_BRIGHTNESS_EN
            bri_q          <= 4'd0;
`endif
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            cnt_q          <= cnt_d;
            started_q      <= started_d;
            loaded_q       <= loaded_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            swap_done_q    <= swap_done_d;
            colunas_q      <= colunas_d;
            linhas_q       <= linhas_d;
            frame_start_q  <= frame_start_d;
`ifdef MATRIZ_SCAN_BRIGHTNESS_EN
            bri_q          <= bri_d;
`endif
        end
    end

    assign frame_ready = !pending_full_q;
    assign colunas     = colunas_q;
    assign linhas      = linhas_q;
    assign col_index   = col_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_matriz_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_matriz_scan
// Purpose  : Scoreboard bench for matriz_scan. Two instances (default 5x7
//            geometry, and an 8x8 active-low configuration without blanking)
//            are driven with random frames. A cycle-level reference model
//            derives the expected outputs from the frame timing arithmetic
//            and queues them; a monitor pops and compares each cycle.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_matriz_scan;

    localparam int C_NC0 = 5, C_NR0 = 7, C_DW0 = 4, C_BL0 = 1;
    localparam int C_NC1 = 8, C_NR1 = 8, C_DW1 = 2, C_BL1 = 0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [34:0] data0  = '0;
    logic        valid0 = 1'b0;
    logic        ready0;
    logic [4:0]  colunas0;
    logic [6:0]  linhas0;
    logic [2:0]  colidx0;
    logic        fs0;

    logic [63:0] data1  = '0;
    logic        valid1 = 1'b0;
    logic        ready1;
    logic [7:0]  colunas1;
    logic [7:0]  linhas1;
    logic [2:0]  colidx1;
    logic        fs1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    matriz_scan #(
        .NUM_COLS(C_NC0), .NUM_ROWS(C_NR0), .DWELL(C_DW0), .BLANK_CYCLES(C_BL0),
        .COL_ACTIVE_LOW(0), .ROW_ACTIVE_LOW(0)
    ) u_dut0 (
        .clock(clock), .reset(reset),
        .frame_data(data0), .frame_valid(valid0), .frame_ready(ready0),
`ifdef MATRIZ_SCAN_BRIGHTNESS_EN
        .brightness(4'd15),
`endif
        .colunas(colunas0), .linhas(linhas0), .col_index(colidx0), .frame_start(fs0)
    );

    matriz_scan #(
        .NUM_COLS(C_NC1), .NUM_ROWS(C_NR1), .DWELL(C_DW1), .BLANK_CYCLES(C_BL1),
        .COL_ACTIVE_LOW(1), .ROW_ACTIVE_LOW(1)
    ) u_dut1 (
        .clock(clock), .reset(reset),
        .frame_data(data1), .frame_valid(valid1), .frame_ready(ready1),
`ifdef MATRIZ_SCAN_BRIGHTNESS_EN
        .brightness(4'd15),
`endif
        .colunas(colunas1), .linhas(linhas1), .col_index(colidx1), .frame_start(fs1)
    );

    // ------------------------------------------------------------------
    // Reference model: cycle t counts from the first cycle of the column 0
    // slot after reset. Slot = t / (BLANK+DWELL), column = slot mod NUM_COLS.
    // A pending frame becomes the displayed one at each frame boundary.
    // ------------------------------------------------------------------
    typedef struct {
        logic [63:0] cols;
        logic [63:0] rows;
        int          col;
        bit          ready;
        bit          fs;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          m_t[2];
    logic [63:0] m_act[2];
    logic [63:0] m_pend[2];
    bit          m_pfull[2];
    bit          m_clr[2];
    bit          m_loaded[2];

    function automatic exp_t model_step(int k, bit rst, bit vld, logic [63:0] data,
                                        int nc, int nr, int dw, int bl, bit cl, bit rl);
        exp_t        e;
        logic [63:0] cmask;
        logic [63:0] rmask;
        int          slot;
        int          per;
        int          col;
        bit          wrap;
        bit          newclr;
        bit          accept;
        cmask = (64'd1 << nc) - 64'd1;
        rmask = (64'd1 << nr) - 64'd1;
        slot  = bl + dw;
        per   = nc * slot;
        if (rst) begin
            m_t[k] = -1; m_act[k] = '0; m_pend[k] = '0;
            m_pfull[k] = 0; m_clr[k] = 0; m_loaded[k] = 0;
            e.cols = cl ? cmask : '0;
            e.rows = rl ? rmask : '0;
            e.col = 0; e.ready = 1; e.fs = 0;
            return e;
        end
        wrap   = (m_t[k] >= 0) && (((m_t[k] + 1) % per) == 0);
        newclr = 0;
        if (wrap && m_pfull[k]) begin
            m_act[k] = m_pend[k];
            m_loaded[k] = 1;
            newclr = 1;
        end
        accept = vld && !m_pfull[k];
        if (m_clr[k]) m_pfull[k] = 0;
        if (accept) begin
            m_pend[k]  = data;
            m_pfull[k] = 1;
        end
        m_clr[k] = newclr;
        m_t[k]   = m_t[k] + 1;

        col     = (m_t[k] / slot) % nc;
        e.col   = col;
        e.fs    = (m_t[k] % per) == 0;
        e.ready = !m_pfull[k];
        if (((m_t[k] % slot) >= bl) && m_loaded[k]) begin
            e.cols = 64'd1 << col;
            e.rows = (m_act[k] >> (col * nr)) & rmask;
        end else begin
            e.cols = '0;
            e.rows = '0;
        end
        if (cl) e.cols = e.cols ^ cmask;
        if (rl) e.rows = e.rows ^ rmask;
        return e;
    endfunction

    always @(posedge clock) begin
        q0.push_back(model_step(0, reset, valid0, 64'(data0), C_NC0, C_NR0, C_DW0, C_BL0, 1'b0, 1'b0));
        q1.push_back(model_step(1, reset, valid1, data1, C_NC1, C_NR1, C_DW1, C_BL1, 1'b1, 1'b1));
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    task automatic chk(string nm, logic [63:0] got, logic [63:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, required %0h", nm, $time, got, req);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("colunas0",     64'(colunas0), e.cols);
            chk("linhas0",      64'(linhas0),  e.rows);
            chk("col_index0",   64'(colidx0),  64'(e.col));
            chk("frame_ready0", 64'(ready0),   64'(e.ready));
            chk("frame_start0", 64'(fs0),      64'(e.fs));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("colunas1",     64'(colunas1), e.cols);
            chk("linhas1",      64'(linhas1),  e.rows);
            chk("col_index1",   64'(colidx1),  64'(e.col));
            chk("frame_ready1", 64'(ready1),   64'(e.ready));
            chk("frame_start1", 64'(fs1),      64'(e.fs));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    function automatic logic [63:0] rnd(int k);
        logic [63:0] v;
        v = {$urandom, $urandom};
        if (k == 0) v = v & ((64'd1 << 35) - 64'd1);
        return v;
    endfunction

    task automatic set_in(int k, bit v, logic [63:0] d);
        if (k == 0) begin
            valid0 = v;
            data0  = d[34:0];
        end else begin
            valid1 = v;
            data1  = d;
        end
    endtask

    function automatic bit rdy(int k);
        return (k == 0) ? ready0 : ready1;
    endfunction

    // Holds frame_valid until frame_ready is seen, bounded by a cycle budget.
    task automatic offer(int k, logic [63:0] d);
        int waited;
        waited = 0;
        set_in(k, 1'b1, d);
        while (!rdy(k) && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        n_vec++;
        if (!rdy(k)) begin
            n_bad++;
            $display("FAIL handshake%0d: frame_ready got 0 after %0d cycles, required 1", k, waited);
        end
        @(negedge clock);
        set_in(k, 1'b0, rnd(k));
    endtask

    task automatic rand_run(int k, int nframes);
        for (int i = 0; i < nframes; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clock);
            offer(k, rnd(k));
        end
    endtask

    task automatic wait_timeout(string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: condition got false after bound, required true", nm);
    endtask

    initial begin : main
        logic [63:0] frame_a;
        int          waited;
        frame_a = (64'h01 << 0) | (64'h02 << 7) | (64'h04 << 14) | (64'h08 << 21) | (64'h10 << 28);

        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        fork
            begin
                repeat (4) @(negedge clock);
                offer(0, frame_a);
                offer(0, rnd(0));
                rand_run(0, 8);
            end
            begin
                rand_run(1, 10);
            end
        join
        repeat (40) @(negedge clock);

        // Reset during SHOW of column 2 with a frame pending.
        waited = 0;
        while (!fs0 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!fs0) wait_timeout("frame_start0 wait");
        @(negedge clock);
        offer(0, rnd(0));
        waited = 0;
        while (!(colidx0 == 3'd2 && colunas0 != 5'd0 && !ready0) && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!(colidx0 == 3'd2 && colunas0 != 5'd0 && !ready0)) wait_timeout("column 2 show wait");
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (60) @(negedge clock);

        fork
            rand_run(0, 4);
            rand_run(1, 4);
        join
        repeat (60) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation got no end by %0t, required earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
